// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory target for the MEM-stage load/store port. It accepts one request
//   at a time, performs a byte, half or word access after LATENCY clock edges, and
//   returns the result over a valid/ready response channel. RV32I load extension
//   and store byte lanes are applied here.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words of storage (power of two, >= 4)
//   LATENCY      clock edges from request accept to o_rsp_valid (>= 1)
//
// Ports
//   i_clk         system clock, rising edge
//   i_reset       asynchronous, active-high reset
//   i_req_valid   request present
//   o_req_ready   responder can accept (IDLE only, low while in reset)
//   i_req_write   1 = store, 0 = load
//   i_req_addr    byte address (upper bits ignored, address space wraps)
//   i_req_wdata   store data, low bits used for sb/sh
//   i_req_funct3  000 b, 001 h, 010 w, 100 bu, 101 hu
//   o_rsp_valid   response present
//   i_rsp_ready   consumer takes response
//   o_rsp_rdata   extended load result; 0 for stores and rejected accesses
//   o_rsp_err     access rejected, memory untouched
//
// Build option
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses are rejected
//                          with o_rsp_err. When undefined, the low address bits
//                          are forced to alignment and the access proceeds.
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; accept edge captures it and loads the counter
// WAIT  | counting down; the access executes on the edge where cnt == 1
// RESP  | response held stable until an edge with i_rsp_ready = 1

module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_funct3,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;

  logic          r_write;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_funct3;

  logic [31:0]   r_rdata;
  logic          r_err;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_exec;
  logic          w_sel_write;
  logic [AW+1:0] w_sel_addr;
  logic [31:0]   w_sel_wdata;
  logic [2:0]    w_sel_funct3;

  logic          w_illegal;
  logic          w_misalign;
  logic          w_err;
  logic          w_is_half;
  logic          w_is_word;
  logic [1:0]    w_off;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [3:0]    w_be;
  logic [31:0]   w_lanes;
  logic          w_unused;

  assign w_unused = ^i_req_addr[31:AW+2];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (i_req_valid) w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (r_cnt == CW'(1)) w_state_nxt = RESP;
      RESP: if (i_rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept    = (r_state == IDLE) && i_req_valid && !i_reset;
  assign o_req_ready = (r_state == IDLE) && !i_reset;
  assign o_rsp_valid = (r_state == RESP);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
    end else if (w_accept) begin
      r_cnt    <= CW'(LATENCY - 1);
      r_write  <= i_req_write;
      r_addr   <= i_req_addr[AW+1:0];
      r_wdata  <= i_req_wdata;
      r_funct3 <= i_req_funct3;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // With LATENCY == 1 the access happens on the accept edge, so it must see
  // the live request; otherwise it uses the captured copy.
  assign w_exec = (LATENCY == 1) ? w_accept
                                 : ((r_state == WAIT) && (r_cnt == CW'(1)) && !i_reset);

  assign w_sel_write  = (LATENCY == 1) ? i_req_write          : r_write;
  assign w_sel_addr   = (LATENCY == 1) ? i_req_addr[AW+1:0]   : r_addr;
  assign w_sel_wdata  = (LATENCY == 1) ? i_req_wdata          : r_wdata;
  assign w_sel_funct3 = (LATENCY == 1) ? i_req_funct3         : r_funct3;

  // ------------------------------------------------------ access decode
  assign w_is_half = (w_sel_funct3[1:0] == 2'b01);
  assign w_is_word = (w_sel_funct3 == 3'b010);

  // Unsigned variants (1xx) exist only for loads.
  assign w_illegal = (w_sel_funct3 == 3'b011) || (w_sel_funct3 == 3'b110) ||
                     (w_sel_funct3 == 3'b111) || (w_sel_funct3[2] && w_sel_write);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misalign = (w_is_half && w_sel_addr[0]) ||
                      (w_is_word && (w_sel_addr[1:0] != 2'b00));
  assign w_off      = w_sel_addr[1:0];
`else
  assign w_misalign = 1'b0;
  assign w_off      = w_is_word ? 2'b00 :
                      w_is_half ? {w_sel_addr[1], 1'b0} : w_sel_addr[1:0];
`endif

  assign w_err  = w_illegal || w_misalign;
  assign w_idx  = w_sel_addr[AW+1:2];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load = '0;
    case (w_sel_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      3'b010:  w_load = w_word;
      default: w_load = '0;
    endcase
  end

  always_comb begin
    w_be    = 4'b0000;
    w_lanes = w_sel_wdata;
    if (w_is_word) begin
      w_be = 4'b1111;
    end else if (w_is_half) begin
      w_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_lanes = {2{w_sel_wdata[15:0]}};
    end else begin
      w_be    = 4'b0001 << w_off;
      w_lanes = {4{w_sel_wdata[7:0]}};
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_exec && w_sel_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_lanes[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_exec) begin
      r_rdata <= (w_sel_write || w_err) ? 32'h0 : w_load;
      r_err   <= w_err;
    end
  end

endmodule
